// File: rtl/spi_frame_rx_if.sv
// Register-file side of the SPI frame receiver: write port, read port and error pulse.
interface spi_frame_rx_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_err;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_addr, frame_err,
    input  rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_addr, frame_err,
    output rd_data
  );
endinterface

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave: synchronises the pins into clk, assembles command+data frames,
// issues register writes and shifts register reads back out on MISO.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            spi_sck,
  input  logic            spi_cs_n,
  input  logic            spi_mosi,
  output logic            spi_miso,
  spi_frame_rx_if.master  regs
);
  localparam int FRAME_LEN = ADDR_W + 1 + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, CMD, RDLOAD, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_LEN-3:0]   rx_shift;
  logic [DATA_W-2:0]      tx_shift;
  logic                   is_read;
  logic                   overrun;
  logic [FRAME_LEN-2:0]   rx_next;
  logic [ADDR_W:0]        cmd_next;

  // Synchronisers carry no reset so a reset mid-frame cannot fake a chip-select edge.
  always_ff @(posedge clk) begin
    sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    sck_d     <= sck_sync[SYNC_STAGES-1];
    cs_d      <= cs_sync[SYNC_STAGES-1];
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // The command MSB is consumed into is_read, so the shifter never needs to hold it.
  assign rx_next  = {rx_shift, mosi_s};
  assign cmd_next = {rx_shift[ADDR_W-1:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      is_read        <= 1'b0;
      overrun        <= 1'b0;
      spi_miso       <= 1'b0;
      regs.wr_valid  <= 1'b0;
      regs.wr_addr   <= '0;
      regs.wr_data   <= '0;
      regs.rd_addr   <= '0;
      regs.frame_err <= 1'b0;
    end else begin
      regs.wr_valid  <= 1'b0;
      regs.frame_err <= 1'b0;
      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          if (cs_fall) begin
            state    <= CMD;
            bit_cnt  <= '0;
            rx_shift <= '0;
            overrun  <= 1'b0;
          end
        end
        CMD: begin
          if (cs_rise) begin
            regs.frame_err <= (bit_cnt != '0);
            state          <= IDLE;
          end else if (sck_rise) begin
            rx_shift <= rx_next[FRAME_LEN-3:0];
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == CMD_LAST) begin
              is_read      <= cmd_next[ADDR_W];
              regs.rd_addr <= cmd_next[ADDR_W-1:0];
              state        <= cmd_next[ADDR_W] ? RDLOAD : DATA;
            end
          end
        end
        RDLOAD: begin
          if (cs_rise) begin
            regs.frame_err <= 1'b1;
            state          <= IDLE;
          end else begin
            spi_miso <= regs.rd_data[DATA_W-1];
            tx_shift <= regs.rd_data[DATA_W-2:0];
            state    <= DATA;
          end
        end
        DATA: begin
          if (cs_rise) begin
            regs.frame_err <= 1'b1;
            spi_miso       <= 1'b0;
            state          <= IDLE;
          end else begin
            if (sck_rise) begin
              rx_shift <= rx_next[FRAME_LEN-3:0];
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == FRAME_LAST) begin
                state <= DONE;
                if (!is_read) begin
                  regs.wr_valid <= 1'b1;
                  regs.wr_addr  <= rx_next[DATA_W +: ADDR_W];
                  regs.wr_data  <= rx_next[DATA_W-1:0];
                end
              end
            end
            // The fall right after the command byte keeps the MSB on the line for data bit one.
            if (sck_fall && is_read && (bit_cnt > CMD_LAST + 1'b1)) begin
              spi_miso <= tx_shift[DATA_W-2];
              tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (cs_rise) begin
            regs.frame_err <= overrun;
            spi_miso       <= 1'b0;
            state          <= IDLE;
          end else if (sck_rise) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: expected writes are queued as frames are driven
// and matched against wr_valid strobes; frame_err pulses are counted against a model.
module tb_spi_frame_rx;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int SYNC   = 2;
  localparam int HALF   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;

  spi_frame_rx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  assign bus.rd_data = (bus.rd_addr == 7'h12) ? 8'h3C : {1'b0, bus.rd_addr};

  spi_frame_rx #(.SYNC_STAGES(SYNC), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .regs     (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          errSeen = 0;
  int          errExpected = 0;
  logic [14:0] wrQueue[$];
  logic [14:0] expWr;
  time         lastRise = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Every write strobe must match the oldest queued frame and arrive promptly.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_valid) begin
        if (wrQueue.size() == 0) begin
          checkOutput("wr_unexpected", 32'd1, 32'd0);
        end else begin
          expWr = wrQueue.pop_front();
          checkOutput("wr_addr", 32'(bus.wr_addr), 32'(expWr[14:8]));
          checkOutput("wr_data", 32'(bus.wr_data), 32'(expWr[7:0]));
          checkOutput("wr_latency", 32'(($time - lastRise) <= (SYNC + 2) * 10), 32'd1);
        end
      end
      if (bus.frame_err) errSeen++;
      if (bus.wr_valid && bus.frame_err) checkOutput("wr_err_overlap", 32'd1, 32'd0);
    end
  end

  task automatic driveBit(input logic b, output logic misoBit);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    spi_sck  = 1'b1;
    lastRise = $time;
    misoBit  = spi_miso;
    repeat (HALF) @(negedge clk);
    spi_sck  = 1'b0;
  endtask

  // word carries nbits of frame, MSB first, right-aligned.
  task automatic applyStimulus(input logic [31:0] word, input int nbits, output logic [7:0] misoByte);
    logic [15:0] f;
    logic        m;
    misoByte = 8'h00;
    if (nbits >= 16) begin
      f = 16'(word >> (nbits - 16));
      if (!f[15]) wrQueue.push_back(f[14:0]);
    end
    if ((nbits > 0 && nbits < 16) || nbits > 16) errExpected++;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      driveBit(word[nbits-1-i], m);
      if (i >= 8 && i < 16) misoByte = {misoByte[6:0], m};
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic drainAndCheck(input string tag);
    for (int k = 0; k < 50 && wrQueue.size() != 0; k++) @(negedge clk);
    checkOutput({tag, "_wr_pending"}, 32'(wrQueue.size()), 32'd0);
    checkOutput({tag, "_frame_err_count"}, 32'(errSeen), 32'(errExpected));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  misoByte;
    logic        m;
    logic [15:0] partial;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("reset_wr_valid", 32'(bus.wr_valid), 32'd0);
    checkOutput("reset_frame_err", 32'(bus.frame_err), 32'd0);
    checkOutput("reset_miso", 32'(spi_miso), 32'd0);
    checkOutput("reset_wr_addr", 32'(bus.wr_addr), 32'd0);

    applyStimulus(32'h05A5, 16, misoByte);
    drainAndCheck("write");

    applyStimulus(32'h9200, 16, misoByte);
    checkOutput("rd_addr", 32'(bus.rd_addr), 32'h12);
    checkOutput("miso_byte", 32'(misoByte), 32'h3C);
    drainAndCheck("read");

    applyStimulus(32'h05A5 >> 5, 11, misoByte);
    drainAndCheck("abort");
    applyStimulus(32'h017F, 16, misoByte);
    drainAndCheck("after_abort");

    applyStimulus(32'h02110, 20, misoByte);
    drainAndCheck("overrun");

    // Reset lands after nine bits with chip select still low.
    partial = 16'h0AA5;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 9; i++) driveBit(partial[15-i], m);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_wr_valid", 32'(bus.wr_valid), 32'd0);
    checkOutput("midrst_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("midrst_wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("midrst_rd_addr", 32'(bus.rd_addr), 32'd0);
    checkOutput("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    checkOutput("midrst_miso", 32'(spi_miso), 32'd0);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    drainAndCheck("midrst");
    applyStimulus(32'h04FF, 16, misoByte);
    drainAndCheck("after_rst");

    applyStimulus(32'h0000, 16, misoByte);
    applyStimulus(32'h7F80, 16, misoByte);
    drainAndCheck("back_to_back");
    checkOutput("final_wr_addr", 32'(bus.wr_addr), 32'h7F);
    checkOutput("final_wr_data", 32'(bus.wr_data), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
